// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle controller.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    typedef enum logic [3:0] {
        CLS_NONE, CLS_R, CLS_I, CLS_LD, CLS_SD, CLS_BR, CLS_JAL,
        CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_SYS, CLS_ILL
    } cls_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_UPPER = 2'b11;

    // EXEC-state controls; condPc means pc_write follows branch_taken
    typedef struct packed {
        logic       aluSrc;
        logic [1:0] aluOp;
        logic       branch;
        logic       jumpReg;
        logic       pcWrite;
        logic       pcSrc;
        logic       condPc;
    } exec_ctl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier and per-class EXEC control table (purely combinational).
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  cls_t       cls,
    output cls_t       opCls,
    output exec_ctl_t  execCtl
);

    // Classify the raw opcode; anything unlisted is illegal
    always_comb begin
        opCls = CLS_ILL;
        case (opcode)
            OP_R:     opCls = CLS_R;
            OP_I:     opCls = CLS_I;
            OP_LD:    opCls = CLS_LD;
            OP_SD:    opCls = CLS_SD;
            OP_BR:    opCls = CLS_BR;
            OP_JAL:   opCls = CLS_JAL;
            OP_JALR:  opCls = CLS_JALR;
            OP_LUI:   opCls = CLS_LUI;
            OP_AUIPC: opCls = CLS_AUIPC;
            OP_SYS:   opCls = CLS_SYS;
            default:  opCls = CLS_ILL;
        endcase
    end

    // EXEC controls for the latched class
    always_comb begin
        execCtl = '0;
        case (cls)
            CLS_R: begin
                execCtl.aluOp = ALU_FUNCT;
            end
            CLS_I: begin
                execCtl.aluSrc = 1'b1;
                execCtl.aluOp  = ALU_FUNCT;
            end
            CLS_LD, CLS_SD: begin
                execCtl.aluSrc = 1'b1;
                execCtl.aluOp  = ALU_ADD;
            end
            CLS_BR: begin
                execCtl.aluOp  = ALU_CMP;
                execCtl.branch = 1'b1;
                execCtl.pcSrc  = 1'b1;
                execCtl.condPc = 1'b1;
            end
            CLS_JAL: begin
                execCtl.aluOp   = ALU_UPPER;
                execCtl.branch  = 1'b1;
                execCtl.pcWrite = 1'b1;
                execCtl.pcSrc   = 1'b1;
            end
            CLS_JALR: begin
                execCtl.aluOp   = ALU_FUNCT;
                execCtl.branch  = 1'b1;
                execCtl.jumpReg = 1'b1;
                execCtl.pcWrite = 1'b1;
                execCtl.pcSrc   = 1'b1;
            end
            CLS_LUI, CLS_AUIPC: begin
                execCtl.aluSrc = 1'b1;
                execCtl.aluOp  = ALU_UPPER;
            end
            default: execCtl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control FSM: sequences FETCH/DECODE/EXEC/MEM/WB,
// times out stalled memory accesses, and halts on SYSTEM/illegal/bus error.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       branch,
    output logic       jump_reg,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic       bus_err,
    output logic       halted
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t          state;
    cls_t            cls;
    cls_t            decCls;
    exec_ctl_t       execCtl;
    logic [CNT_W-1:0] waitCnt;
    logic            illegalQ;
    logic            busErrQ;
    logic            timeout;

    ctrl_decode uDecode (
        .opcode  (opcode),
        .cls     (cls),
        .opCls   (decCls),
        .execCtl (execCtl)
    );

    // Last permitted wait cycle: ready now completes, otherwise trap
    assign timeout = (waitCnt == CNT_W'(MEM_TIMEOUT - 1));

    // State sequencing, class latch, wait counter and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cls      <= CLS_NONE;
            waitCnt  <= '0;
            illegalQ <= 1'b0;
            busErrQ  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state   <= ST_FETCH;
                    waitCnt <= '0;
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        state   <= ST_DECODE;
                        waitCnt <= '0;
                    end else if (timeout) begin
                        state   <= ST_HALT;
                        busErrQ <= 1'b1;
                        waitCnt <= '0;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                ST_DECODE: begin
                    cls     <= decCls;
                    waitCnt <= '0;
                    case (decCls)
                        CLS_SYS: state <= ST_HALT;
                        CLS_ILL: begin
                            state    <= ST_HALT;
                            illegalQ <= 1'b1;
                        end
                        default: state <= ST_EXEC;
                    endcase
                end
                ST_EXEC: begin
                    waitCnt <= '0;
                    case (cls)
                        CLS_LD, CLS_SD: state <= ST_MEM;
                        CLS_BR:         state <= ST_FETCH;
                        default:        state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        state   <= (cls == CLS_LD) ? ST_WB : ST_FETCH;
                        waitCnt <= '0;
                    end else if (timeout) begin
                        state   <= ST_HALT;
                        busErrQ <= 1'b1;
                        waitCnt <= '0;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                ST_WB: begin
                    state   <= ST_FETCH;
                    waitCnt <= '0;
                end
                ST_HALT: state <= ST_HALT;
                default: begin
                    state   <= ST_IDLE;
                    waitCnt <= '0;
                end
            endcase
        end
    end

    // Moore decode of state/class; FETCH and MEM strobes also see mem_ready
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        branch     = 1'b0;
        jump_reg   = 1'b0;
        alu_op     = ALU_ADD;
        illegal    = illegalQ;
        bus_err    = busErrQ;
        halted     = (state == ST_HALT);
        case (state)
            ST_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            ST_EXEC: begin
                alu_src  = execCtl.aluSrc;
                alu_op   = execCtl.aluOp;
                branch   = execCtl.branch;
                jump_reg = execCtl.jumpReg;
                pc_src   = execCtl.pcSrc;
                pc_write = execCtl.pcWrite | (execCtl.condPc & branch_taken);
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls == CLS_SD);
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls == CLS_LD);
            end
            default: ;
        endcase
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle successor to the single-cycle opcode decoder. It sequences each RV32 instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the datapath control lines (ALU source, write-back select, register write, memory request, branch/jump, ALU op) only in the states where they apply. It also adds a memory ready/timeout handshake, traps on illegal opcodes, and halts on SYSTEM (1110011). It sits between the instruction register and the shared datapath of the multi-cycle core.

## Interface
- MEM_TIMEOUT, 16: maximum wait cycles for `mem_ready` in FETCH or MEM before trapping; must be ≥1.
- CNT_W, $clog2(MEM_TIMEOUT+1): width of the wait counter; derived, not overridden.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  instr[6:0] from the IR; sampled in DECODE only.
- branch_taken  in  1  ALU compare result; sampled in EXEC only.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request (fetch or data).
- mem_we  out  1  data write; valid only with `mem_req` in MEM.
- ir_write  out  1  load the IR; asserted in the FETCH cycle where `mem_ready`=1.
- pc_write  out  1  update the PC.
- pc_src  out  1  0: PC+4; 1: branch/jump target.
- alu_src, mem_to_reg, reg_write, branch, jump_reg  out  1 each  datapath controls.
- alu_op  out  2  ALU control class: 00 add, 01 compare, 10 funct-decoded, 11 upper-immediate/jal.
- illegal  out  1  sticky flag for an illegal opcode.
- bus_err  out  1  sticky flag for a memory timeout.
- halted  out  1  core stopped (SYSTEM, illegal, or timeout).

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset:
  - State goes to IDLE.
  - All outputs are 0; the wait counter is 0 and the latched opcode class is NONE.
  - IDLE always moves to FETCH on the next clock.
- FETCH:
  - `mem_req`=1 and `mem_we`=0.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=0, then go to DECODE.
  - Otherwise the wait counter increments.
- DECODE:
  - Classify `opcode` as R, I, LD, SD, BR, JAL, JALR, LUI, AUIPC, SYS or ILL, and latch the class.
  - SYS goes to HALT with `halted`=1.
  - ILL goes to HALT with `illegal`=1 and `halted`=1.
  - All other classes go to EXEC.
- EXEC: `alu_src` and `alu_op` per class, held for 1 cycle.
  - R: `alu_src`=0, `alu_op`=10.
  - I: `alu_src`=1, `alu_op`=10.
  - LD/SD: `alu_src`=1, `alu_op`=00.
  - BR: `alu_src`=0, `alu_op`=01, `branch`=1. `pc_write`=`branch_taken` with `pc_src`=1. Next state is FETCH.
  - JAL: `alu_op`=11, `branch`=1, `pc_write`=1, `pc_src`=1.
  - JALR: as JAL, plus `jump_reg`=1 and `alu_op`=10.
  - LUI/AUIPC: `alu_src`=1, `alu_op`=11.
  - Next state: LD/SD go to MEM; BR goes to FETCH; every other class goes to WB.
- MEM:
  - `mem_req`=1; `mem_we`=1 for SD only.
  - On `mem_ready`: LD goes to WB, SD goes to FETCH.
- WB:
  - `reg_write`=1 for 1 cycle.
  - `mem_to_reg`=1 for LD only.
  - Next state is FETCH.
- Wait counter:
  - Clears on every state entry.
  - Reaching MEM_TIMEOUT with `mem_ready` still 0 sends the FSM to HALT with `bus_err`=1 and `halted`=1.
  - `mem_ready` arriving in the same cycle the count is reached wins: normal completion, no trap.
- HALT:
  - Absorbing state; all strobes are 0.
  - Only `rst_n` exits it.
- `mem_ready` outside FETCH/MEM is ignored.
- Every output not listed for a state is 0. No output holds a previous value.

## Timing
- Outputs are combinational decode of the registered state and latched class (Moore style). FETCH/MEM strobes also depend on `mem_ready`.
- Cycles per instruction with zero-wait memory:
  - R, I, LUI, AUIPC, JAL, JALR: 4.
  - LD: 5.
  - SD: 4.
  - BR: 3.
- Each memory wait cycle adds 1 cycle.
- Asserting `rst_n` low mid-instruction forces IDLE and zero outputs immediately (asynchronous). An in-flight `mem_req` is dropped in the same cycle.
- The first `mem_req` appears 1 cycle after reset deassertion.

## Structure
- Shared package `ctrl_pkg`:
  - State enum.
  - Opcode constants (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011).
  - Class enum.
  - `alu_op` encodings.
- One combinational sub-module, `ctrl_decode`: opcode to class, plus per-class EXEC control values. It is instantiated once, and the FSM and wait counter live in `multicycle_ctrl`.

## Test plan
- Reset, then R-type (0110011) with `mem_ready` tied 1:
  - IDLE→FETCH→DECODE→EXEC→WB→FETCH.
  - `reg_write` pulses exactly once, at cycle 5 after reset release.
  - `alu_op`=10 in EXEC.
- LD with `mem_ready` low for 3 cycles in MEM:
  - `mem_req` is held for 4 cycles and `mem_we`=0.
  - WB has `mem_to_reg`=1 and `reg_write`=1.
  - Total 8 cycles.
- BR with `branch_taken`=0 and then =1:
  - 3-cycle instruction.
  - EXEC `pc_write`=0 then 1 (`pc_src`=1).
  - `reg_write` never asserts.
- Opcode 1111111: HALT with `illegal`=1 and `halted`=1; all strobes stay 0 for 20 further cycles.
- FETCH with `mem_ready` stuck 0 and MEM_TIMEOUT=4:
  - `bus_err`=1 after 4 wait cycles.
  - A rerun with `mem_ready`=1 on the 4th cycle completes normally.
- `rst_n` pulsed low during MEM of an SD:
  - `mem_req` and `mem_we` drop to 0 asynchronously.
  - FSM restarts at IDLE→FETCH.
